qspi_ram_responder: RTL and testbench



---
 rtl/qspi_ram_responder.sv | 217 +++++++++++++++++++++
 tb/tb_qspi_ram_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/qspi_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_ram_responder
//  Purpose  : QPI-mode RAM target for the framebuffer QSPI bus. Decodes an
//             8-bit opcode (two nibbles), a 24-bit address (six nibbles) and,
//             for reads, a run of dummy cycles, then streams nibbles out of or
//             into an internal byte array (high nibble first).
//  Ports    : clk        - clock, one bus nibble per cycle while selected
//             rst_n      - synchronous active-low reset
//             cs_n       - chip select, active-low
//             bus_in     - nibble from the master
//             bus_out    - nibble to the master (valid while bus_oe=1)
//             bus_oe     - responder drive enable, set only while sending data
//             busy       - transaction in progress (state not IDLE)
//             cmd_error  - one-cycle pulse on an unrecognised opcode
//             dbg_addr   - backdoor byte address
//             dbg_data   - mem[dbg_addr], one cycle of latency
//  Revision : 1.0 - initial release
// ============================================================================
module qspi_ram_responder #(
  parameter int         ADDR_BITS    = 10,
  parameter int         DUMMY_CYCLES = 6,
  parameter logic [7:0] CMD_READ     = 8'hEB,
  parameter logic [7:0] CMD_WRITE    = 8'h38
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic [3:0]           bus_in,
  output logic [3:0]           bus_out,
  output logic                 bus_oe,
  output logic                 busy,
  output logic                 cmd_error,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [7:0]           dbg_data
);

  // Counter covers both the six address nibbles and the dummy run.
  localparam int CNT_W = $clog2(DUMMY_CYCLES + 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    READ   = 3'd4,
    WRITE  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  logic [7:0] mem [0:(2**ADDR_BITS)-1];

  state_t               state_q,     state_d;
  logic [3:0]           op_hi_q,     op_hi_d;
  logic                 is_read_q,   is_read_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [ADDR_BITS-1:0] addr_q,      addr_d;
  logic                 nib_q,       nib_d;      // 1 = high nibble already handled
  logic [3:0]           wr_hi_q,     wr_hi_d;
  logic [3:0]           bus_out_q,   bus_out_d;
  logic                 bus_oe_q,    bus_oe_d;
  logic                 busy_q,      busy_d;
  logic                 cmd_error_q, cmd_error_d;
  logic [7:0]           dbg_data_q;

  logic                 mem_we;
  logic [7:0]           mem_wdata;
  logic [ADDR_BITS-1:0] addr_shift;
  logic [ADDR_BITS-1:0] addr_inc;
  logic [7:0]           opcode;

  // Only the low ADDR_BITS of the 24-bit address survive the shift.
  assign addr_shift = (addr_q << 4) | ADDR_BITS'(bus_in);
  assign addr_inc   = addr_q + ADDR_BITS'(1);
  assign opcode     = {op_hi_q, bus_in};

  always_comb begin
    state_d     = state_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    nib_d       = nib_q;
    wr_hi_d     = wr_hi_q;
    bus_out_d   = bus_out_q;
    bus_oe_d    = bus_oe_q;
    cmd_error_d = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = {wr_hi_q, bus_in};

    if (cs_n) begin
      // Deselect discards any partial command, address or write byte.
      state_d  = IDLE;
      bus_oe_d = 1'b0;
      nib_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          op_hi_d = bus_in;
          state_d = CMD;
        end
        CMD: begin
          if (opcode == CMD_READ || opcode == CMD_WRITE) begin
            is_read_d = (opcode == CMD_READ);
            cnt_d     = '0;
            state_d   = ADDR;
          end else begin
            cmd_error_d = 1'b1;
            state_d     = IGNORE;
          end
        end
        ADDR: begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(5)) begin
            cnt_d = '0;
            nib_d = 1'b0;
            if (!is_read_q) begin
              state_d = WRITE;
            end else if (DUMMY_CYCLES == 0) begin
              // No wait phase: first data nibble comes from the new address.
              bus_out_d = mem[addr_shift][7:4];
              bus_oe_d  = 1'b1;
              state_d   = READ;
            end else begin
              state_d = DUMMY;
            end
          end
        end
        DUMMY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
            bus_out_d = mem[addr_q][7:4];
            bus_oe_d  = 1'b1;
            nib_d     = 1'b0;
            state_d   = READ;
          end
        end
        READ: begin
          if (!nib_q) begin
            bus_out_d = mem[addr_q][3:0];
            nib_d     = 1'b1;
          end else begin
            addr_d    = addr_inc;
            bus_out_d = mem[addr_inc][7:4];
            nib_d     = 1'b0;
          end
        end
        WRITE: begin
          if (!nib_q) begin
            wr_hi_d = bus_in;
            nib_d   = 1'b1;
          end else begin
            mem_we = 1'b1;
            addr_d = addr_inc;
            nib_d  = 1'b0;
          end
        end
        IGNORE: begin
          bus_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          bus_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_hi_q     <= '0;
      is_read_q   <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      nib_q       <= 1'b0;
      wr_hi_q     <= '0;
      bus_out_q   <= '0;
      bus_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      dbg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_hi_q     <= op_hi_d;
      is_read_q   <= is_read_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      nib_q       <= nib_d;
      wr_hi_q     <= wr_hi_d;
      bus_out_q   <= bus_out_d;
      bus_oe_q    <= bus_oe_d;
      busy_q      <= busy_d;
      cmd_error_q <= cmd_error_d;
      // Same-edge write to dbg_addr returns the old byte.
      dbg_data_q  <= mem[dbg_addr];
    end
  end

  // Memory contents are intentionally not reset; reset blocks new commits.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign busy      = busy_q;
  assign cmd_error = cmd_error_q;
  assign dbg_data  = dbg_data_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qspi_ram_responder
//  Purpose  : Directed bench for qspi_ram_responder: write/readback, quad read
//             timing, address wrap, partial byte, bad opcode and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_ram_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] bus_in = '0;
  logic [3:0] bus_out;
  logic       bus_oe;
  logic       busy;
  logic       cmd_error;
  logic [9:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int checks = 0;
  int failures = 0;

  qspi_ram_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .busy      (busy),
    .cmd_error (cmd_error),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable for the cycle that follows.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    cs_n   = 1'b0;
    bus_in = n;
    tick();
  endtask

  task automatic deselect();
    cs_n   = 1'b1;
    bus_in = 4'h0;
    tick();
  endtask

  // Opcode plus 24-bit address: k=0..7.
  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    send_nib(op[7:4]);
    send_nib(op[3:0]);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic dbg_check(input string tag, input logic [9:0] a, input logic [7:0] exp);
    dbg_addr = a;
    tick();
    chk(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  initial begin
    // ---- reset state ----
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_bus_oe",    {31'h0, bus_oe},    32'h0);
    chk("rst_busy",      {31'h0, busy},      32'h0);
    chk("rst_cmd_error", {31'h0, cmd_error}, 32'h0);
    chk("rst_bus_out",   {28'h0, bus_out},   32'h0);
    chk("rst_dbg_data",  {24'h0, dbg_data},  32'h0);
    rst_n = 1'b1;
    tick();

    // ---- write / readback ----
    send_nib(4'h3);
    chk("wr_busy_k0", {31'h0, busy}, 32'h1);
    send_nib(4'h8);
    for (int i = 5; i >= 0; i--) send_nib(4'(24'h000010 >> (i*4)));
    send_nib(4'hA);
    send_nib(4'h5);
    send_nib(4'h3);
    send_nib(4'hC);
    chk("wr_oe_low", {31'h0, bus_oe}, 32'h0);
    deselect();
    chk("wr_busy_end", {31'h0, busy}, 32'h0);
    dbg_check("dbg_10", 10'h010, 8'hA5);
    dbg_check("dbg_11", 10'h011, 8'h3C);

    // ---- quad read from 0x10 ----
    send_hdr(8'hEB, 24'h000010);
    for (int i = 0; i < 5; i++) send_nib(4'h0);   // k=8..12
    chk("rd_oe_k13", {31'h0, bus_oe}, 32'h0);
    send_nib(4'h0);                               // k=13, last dummy
    chk("rd_oe_k14",  {31'h0, bus_oe},  32'h1);
    chk("rd_out_k14", {28'h0, bus_out}, 32'hA);
    send_nib(4'h0);
    chk("rd_out_k15", {28'h0, bus_out}, 32'h5);
    send_nib(4'h0);
    chk("rd_out_k16", {28'h0, bus_out}, 32'h3);
    send_nib(4'h0);
    chk("rd_out_k17", {28'h0, bus_out}, 32'hC);
    chk("rd_busy",    {31'h0, busy},    32'h1);
    deselect();
    chk("rd_oe_end",   {31'h0, bus_oe}, 32'h0);
    chk("rd_busy_end", {31'h0, busy},   32'h0);

    // ---- wrap write at 0x3FF ----
    send_hdr(8'h38, 24'h0003FF);
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h3);
    send_nib(4'h4);
    deselect();
    dbg_check("wrap_3ff", 10'h3FF, 8'h12);
    dbg_check("wrap_000", 10'h000, 8'h34);

    send_hdr(8'hEB, 24'h0003FF);
    for (int i = 0; i < 6; i++) send_nib(4'h0);
    chk("wrap_rd0", {28'h0, bus_out}, 32'h1);
    send_nib(4'h0);
    chk("wrap_rd1", {28'h0, bus_out}, 32'h2);
    send_nib(4'h0);
    chk("wrap_rd2", {28'h0, bus_out}, 32'h3);
    send_nib(4'h0);
    chk("wrap_rd3", {28'h0, bus_out}, 32'h4);
    deselect();

    // ---- partial byte at 0x20 (seed a known value first) ----
    send_hdr(8'h38, 24'h000020);
    send_nib(4'h5);
    send_nib(4'hA);
    deselect();
    send_hdr(8'h38, 24'h000020);
    send_nib(4'hF);
    deselect();
    chk("part_busy", {31'h0, busy}, 32'h0);
    dbg_check("part_mem20", 10'h020, 8'h5A);

    // ---- bad opcode 0x9F ----
    send_nib(4'h9);
    chk("bad_err_k0", {31'h0, cmd_error}, 32'h0);
    send_nib(4'hF);
    chk("bad_err_k1", {31'h0, cmd_error}, 32'h1);
    send_nib(4'h0);
    chk("bad_err_k2", {31'h0, cmd_error}, 32'h0);
    for (int i = 0; i < 5; i++) send_nib(4'h0);
    send_nib(4'h1);
    send_nib(4'h0);
    send_nib(4'hF);
    send_nib(4'hF);
    for (int i = 0; i < 6; i++) send_nib(4'h0);
    chk("bad_oe", {31'h0, bus_oe}, 32'h0);
    chk("bad_busy", {31'h0, busy}, 32'h1);
    deselect();
    dbg_check("bad_mem10", 10'h010, 8'hA5);
    send_hdr(8'hEB, 24'h000011);
    for (int i = 0; i < 6; i++) send_nib(4'h0);
    chk("after_bad_oe",  {31'h0, bus_oe},  32'h1);
    chk("after_bad_hi",  {28'h0, bus_out}, 32'h3);
    send_nib(4'h0);
    chk("after_bad_lo",  {28'h0, bus_out}, 32'hC);
    deselect();

    // ---- reset abort during read k=15 ----
    send_hdr(8'hEB, 24'h000010);
    for (int i = 0; i < 6; i++) send_nib(4'h0);   // k=8..13
    send_nib(4'h0);                               // k=14
    chk("abort_pre_out", {28'h0, bus_out}, 32'h5);
    rst_n  = 1'b0;                                // during k=15
    cs_n   = 1'b0;
    tick();
    chk("abort_oe",   {31'h0, bus_oe}, 32'h0);
    chk("abort_busy", {31'h0, busy},   32'h0);
    rst_n = 1'b1;
    deselect();
    send_hdr(8'hEB, 24'h000011);
    for (int i = 0; i < 6; i++) send_nib(4'h0);
    chk("abort_rd_hi", {28'h0, bus_out}, 32'h3);
    send_nib(4'h0);
    chk("abort_rd_lo", {28'h0, bus_out}, 32'hC);
    deselect();
    dbg_check("abort_mem10", 10'h010, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
